// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - binary32 field widths, op codes, unpacked-float type and helpers for coprocessor_1
package fpu_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_ABS = 3'd3;
  localparam logic [2:0] OP_NEG = 3'd4;
  localparam logic [2:0] OP_MOV = 3'd5;
  localparam logic [2:0] OP_CEQ = 3'd6;
  localparam logic [2:0] OP_CLT = 3'd7;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W:0]   sig;
    logic              is_zero;
    logic              is_inf;
    logic              is_nan;
  } fp_unpacked_t;

  // Denormals collapse to a signed zero with cleared exponent and significand.
  function automatic fp_unpacked_t fp_unpack(input logic [31:0] x);
    fp_unpacked_t u;
    u.sign    = x[31];
    u.exp     = x[30:23];
    u.sig     = {1'b1, x[22:0]};
    u.is_zero = (x[30:23] == 8'h00);
    u.is_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    u.is_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    if (u.is_zero) begin
      u.exp = '0;
      u.sig = '0;
    end
    return u;
  endfunction

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) n = 5'(26 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/fp_round_norm.sv
// rtl/fp_round_norm.sv - normalize, round-to-nearest-even and pack stage shared by ADD/SUB and MUL
// mant_i has its binary point after bit 26 (bit 27 is a carry-out); bits [2:0] are guard/round/sticky.
module fp_round_norm
  import fpu_pkg::*;
(
  input  logic              sign_i,
  input  logic signed [9:0] exp_i,
  input  logic [27:0]       mant_i,
  output logic [31:0]       result_o
`ifdef FPU_FLAGS_EN
  ,
  output logic [1:0]        flags_o
`endif
);

  logic [4:0]        lz;
  logic [26:0]       norm;
  logic signed [9:0] exp_n;
  logic signed [9:0] exp_r;
  logic              round_up;
  logic              rnd_carry;
  logic [22:0]       frac;

  always_comb begin
    lz = lzc27(mant_i[26:0]);
    if (mant_i[27]) begin
      norm  = {mant_i[27:2], mant_i[1] | mant_i[0]};
      exp_n = exp_i + 10'sd1;
    end else begin
      norm  = mant_i[26:0] << lz;
      exp_n = exp_i - $signed({5'b0, lz});
    end

    round_up  = norm[2] & (norm[3] | norm[1] | norm[0]);
    // An all-ones significand that rounds up wraps the fraction to zero and bumps the exponent.
    rnd_carry = (&norm[26:3]) & round_up;
    frac      = norm[25:3] + {22'd0, round_up};
    exp_r     = rnd_carry ? exp_n + 10'sd1 : exp_n;

    if (mant_i == 28'd0) begin
      result_o = 32'h0;
    end else if (exp_r >= 10'sd255) begin
      result_o = {sign_i, POS_INF[30:0]};
    end else if (exp_r <= 10'sd0) begin
      result_o = {sign_i, 31'd0};
    end else begin
      result_o = {sign_i, exp_r[7:0], frac};
    end
  end

`ifdef FPU_FLAGS_EN
  assign flags_o = {(mant_i != 28'd0) && (exp_r >= 10'sd255),
                    (mant_i != 28'd0) && (exp_r <= 10'sd0)};
`endif

endmodule

// File: rtl/coprocessor_1.sv
// rtl/coprocessor_1.sv - single-cycle binary32 COP1 unit (add/sub/mul/abs/neg/mov/ceq/clt), registered result
// Optional FPU_FLAGS_EN adds a registered fpFlags = {invalid, overflow, underflow} output.
module coprocessor_1
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic [2:0]  FloatALUop,
  output logic [31:0] floatRes
`ifdef FPU_FLAGS_EN
  ,
  output logic [2:0]  fpFlags
`endif
);

  fp_unpacked_t      ua;
  fp_unpacked_t      ub;

  logic              b_sign;
  logic              eff_sub;
  logic              a_ge_b;
  logic              big_sign;
  logic [7:0]        big_exp;
  logic [7:0]        small_exp;
  logic [7:0]        exp_diff;
  logic [23:0]       big_sig;
  logic [23:0]       small_sig;
  logic [49:0]       wide;
  logic [26:0]       aligned;
  logic [27:0]       add_mant;
  logic              add_special;
  logic [31:0]       add_special_res;

  logic              mul_sign;
  logic [47:0]       prod;
  logic [27:0]       mul_mant;
  logic signed [9:0] mul_exp;
  logic              mul_special;
  logic [31:0]       mul_special_res;

  logic              rn_sign;
  logic signed [9:0] rn_exp;
  logic [27:0]       rn_mant;
  logic [31:0]       rn_result;

  logic              cmp_eq;
  logic              cmp_lt;
  logic [31:0]       float_res_d;
  logic [31:0]       float_res_q;

`ifdef FPU_FLAGS_EN
  logic [1:0]        rn_flags;
  logic [2:0]        fp_flags_d;
  logic [2:0]        fp_flags_q;
`endif

  assign ua = fp_unpack(data1);
  assign ub = fp_unpack(data2);

  // ADD/SUB: the larger magnitude stays put, the smaller is shifted with guard/round/sticky.
  always_comb begin
    b_sign    = ub.sign ^ (FloatALUop == OP_SUB);
    eff_sub   = ua.sign ^ b_sign;
    a_ge_b    = {ua.exp, ua.sig} >= {ub.exp, ub.sig};
    big_sign  = a_ge_b ? ua.sign : b_sign;
    big_exp   = a_ge_b ? ua.exp : ub.exp;
    big_sig   = a_ge_b ? ua.sig : ub.sig;
    small_exp = a_ge_b ? ub.exp : ua.exp;
    small_sig = a_ge_b ? ub.sig : ua.sig;
    exp_diff  = big_exp - small_exp;
    wide      = {small_sig, 26'd0} >> exp_diff;
    if (exp_diff > 8'd26) begin
      aligned = 27'd1;
    end else begin
      aligned = {wide[49:24], |wide[23:0]};
    end
    if (eff_sub) begin
      add_mant = {1'b0, big_sig, 3'b000} - {1'b0, aligned};
    end else begin
      add_mant = {1'b0, big_sig, 3'b000} + {1'b0, aligned};
    end
  end

  always_comb begin
    add_special     = 1'b1;
    add_special_res = 32'h0;
    if (ua.is_nan || ub.is_nan) begin
      add_special_res = QNAN;
    end else if (ua.is_inf && ub.is_inf) begin
      add_special_res = eff_sub ? QNAN : {ua.sign, POS_INF[30:0]};
    end else if (ua.is_inf) begin
      add_special_res = {ua.sign, POS_INF[30:0]};
    end else if (ub.is_inf) begin
      add_special_res = {b_sign, POS_INF[30:0]};
    end else if (ua.is_zero && ub.is_zero) begin
      add_special_res = {ua.sign & b_sign, 31'd0};
    end else if (ua.is_zero) begin
      add_special_res = {b_sign, data2[30:0]};
    end else if (ub.is_zero) begin
      add_special_res = data1;
    end else begin
      add_special = 1'b0;
    end
  end

  // MUL: 48-bit product folded into the same 28-bit mantissa format the rounder expects.
  always_comb begin
    mul_sign        = ua.sign ^ ub.sign;
    prod            = 48'(ua.sig) * 48'(ub.sig);
    mul_mant        = {prod[47:21], |prod[20:0]};
    mul_exp         = $signed({2'b00, ua.exp}) + $signed({2'b00, ub.exp}) - 10'sd127;
    mul_special     = 1'b1;
    mul_special_res = 32'h0;
    if (ua.is_nan || ub.is_nan) begin
      mul_special_res = QNAN;
    end else if ((ua.is_zero && ub.is_inf) || (ua.is_inf && ub.is_zero)) begin
      mul_special_res = QNAN;
    end else if (ua.is_inf || ub.is_inf) begin
      mul_special_res = {mul_sign, POS_INF[30:0]};
    end else if (ua.is_zero || ub.is_zero) begin
      mul_special_res = {mul_sign, 31'd0};
    end else begin
      mul_special = 1'b0;
    end
  end

  always_comb begin
    if (FloatALUop == OP_MUL) begin
      rn_sign = mul_sign;
      rn_exp  = mul_exp;
      rn_mant = mul_mant;
    end else begin
      rn_sign = big_sign;
      rn_exp  = $signed({2'b00, big_exp});
      rn_mant = add_mant;
    end
  end

  fp_round_norm u_round_norm (
    .sign_i   (rn_sign),
    .exp_i    (rn_exp),
    .mant_i   (rn_mant),
    .result_o (rn_result)
`ifdef FPU_FLAGS_EN
    ,
    .flags_o  (rn_flags)
`endif
  );

  // Signed-magnitude ordering; zeros of either sign compare equal and never less-than.
  always_comb begin
    cmp_eq = 1'b0;
    cmp_lt = 1'b0;
    if (!(ua.is_nan || ub.is_nan)) begin
      if (ua.is_zero && ub.is_zero) begin
        cmp_eq = 1'b1;
      end else begin
        cmp_eq = ({ua.sign, ua.exp, ua.sig} == {ub.sign, ub.exp, ub.sig});
        if (ua.sign != ub.sign) begin
          cmp_lt = ua.sign;
        end else if (ua.sign) begin
          cmp_lt = {ua.exp, ua.sig} > {ub.exp, ub.sig};
        end else begin
          cmp_lt = {ua.exp, ua.sig} < {ub.exp, ub.sig};
        end
      end
    end
  end

  always_comb begin
    float_res_d = 32'h0;
    case (FloatALUop)
      OP_ADD, OP_SUB: float_res_d = add_special ? add_special_res : rn_result;
      OP_MUL:         float_res_d = mul_special ? mul_special_res : rn_result;
      OP_ABS:         float_res_d = {1'b0, data1[30:0]};
      OP_NEG:         float_res_d = {~data1[31], data1[30:0]};
      OP_MOV:         float_res_d = data1;
      OP_CEQ:         float_res_d = {31'd0, cmp_eq};
      OP_CLT:         float_res_d = {31'd0, cmp_lt};
      default:        float_res_d = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      float_res_q <= 32'h0;
    end else begin
      float_res_q <= float_res_d;
    end
  end

  assign floatRes = float_res_q;

`ifdef FPU_FLAGS_EN
  always_comb begin
    fp_flags_d = 3'b000;
    case (FloatALUop)
      OP_ADD, OP_SUB: begin
        if (add_special) begin
          fp_flags_d[2] = !(ua.is_nan || ub.is_nan) && ua.is_inf && ub.is_inf && eff_sub;
        end else begin
          fp_flags_d[1:0] = rn_flags;
        end
      end
      OP_MUL: begin
        if (mul_special) begin
          fp_flags_d[2] = !(ua.is_nan || ub.is_nan) &&
                          ((ua.is_zero && ub.is_inf) || (ua.is_inf && ub.is_zero));
        end else begin
          fp_flags_d[1:0] = rn_flags;
        end
      end
      default: fp_flags_d = 3'b000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fp_flags_q <= 3'b000;
    end else begin
      fp_flags_q <= fp_flags_d;
    end
  end

  assign fpFlags = fp_flags_q;
`endif

endmodule

// File: tb/tb_coprocessor_1.sv
// tb/tb_coprocessor_1.sv - scoreboard bench for coprocessor_1 against a real-arithmetic reference model
module tb_coprocessor_1;

  localparam bit [31:0] QNAN = 32'h7FC00000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [2:0]  op;
  logic [31:0] floatRes;

  coprocessor_1 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data1      (data1),
    .data2      (data2),
    .FloatALUop (op),
    .floatRes   (floatRes)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] want;
  } txn_t;

  txn_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic bit is_nan32(input bit [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Float bits -> double, with denormals flushed to a signed zero.
  function automatic real to_real(input bit [31:0] x);
    bit [63:0] d;
    if (x[30:23] == 8'h00)      d = {x[31], 63'd0};
    else if (x[30:23] == 8'hFF) d = {x[31], 11'h7FF, 52'd0};
    else                        d = {x[31], 11'(int'(x[30:23]) - 127 + 1023), x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  // Double -> float bits: RNE at 24 bits, then saturate to inf or flush to signed zero.
  function automatic bit [31:0] to_float(input real r);
    bit [63:0] d;
    bit [52:0] m;
    bit [24:0] keep;
    bit [28:0] rem;
    int        e;
    d = $realtobits(r);
    if (d[62:52] == 11'h7FF) return (d[51:0] != 52'd0) ? QNAN : {d[63], 8'hFF, 23'd0};
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e    = int'(d[62:52]) - 1023 + 127;
    m    = {1'b1, d[51:0]};
    keep = {1'b0, m[52:29]};
    rem  = m[28:0];
    if (rem > 29'h10000000 || (rem == 29'h10000000 && keep[0])) keep = keep + 25'd1;
    if (keep[24]) begin
      keep = keep >> 1;
      e    = e + 1;
    end
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    if (e <= 0) return {d[63], 31'd0};
    return {d[63], 8'(e), keep[22:0]};
  endfunction

  function automatic bit [31:0] model(input bit [2:0] o, input bit [31:0] a, input bit [31:0] b);
    real ra;
    real rb;
    bit  nan;
    ra  = to_real(a);
    rb  = to_real(b);
    nan = is_nan32(a) || is_nan32(b);
    case (o)
      3'd0:    return nan ? QNAN : to_float(ra + rb);
      3'd1:    return nan ? QNAN : to_float(ra - rb);
      3'd2:    return nan ? QNAN : to_float(ra * rb);
      3'd3:    return {1'b0, a[30:0]};
      3'd4:    return {~a[31], a[30:0]};
      3'd5:    return a;
      3'd6:    return {31'd0, !nan && (ra == rb)};
      default: return {31'd0, !nan && (ra < rb)};
    endcase
  endfunction

  function automatic bit [31:0] rnd_operand(input int base);
    bit [31:0] x;
    int        e;
    x[31]   = 1'($urandom_range(0, 1));
    x[22:0] = 23'($urandom);
    x[30:23] = 8'd127;
    case ($urandom_range(0, 19))
      0: x[30:0] = 31'd0;
      1: x[30:23] = 8'h00;
      2: x[30:0] = {8'hFF, 23'd0};
      3: begin x[30:23] = 8'hFF; x[22] = 1'b1; end
      4: x[30:23] = ($urandom_range(0, 1) != 0) ? 8'd1 : 8'd254;
      default: begin
        e = base + int'($urandom_range(0, 30)) - 15;
        if (e < 1) e = 1;
        if (e > 254) e = 254;
        x[30:23] = 8'(e);
      end
    endcase
    return x;
  endfunction

  task automatic issue(input bit [2:0] o, input bit [31:0] a, input bit [31:0] b, input bit [31:0] want);
    txn_t t;
    @(negedge clk);
    op    = o;
    data1 = a;
    data2 = b;
    t.op   = o;
    t.a    = a;
    t.b    = b;
    t.want = want;
    sb_q.push_back(t);
  endtask

  initial begin : monitor
    txn_t t;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && sb_q.size() > 0) begin
        t = sb_q.pop_front();
        check($sformatf("op%0d a=%h b=%h", t.op, t.a, t.b), floatRes, t.want);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d results still pending", sb_q.size());
    $fatal(1, "watchdog");
  end

  bit [98:0] directed [22] = '{
    {3'd0, 32'h3DCCCCCD, 32'h3F800000, 32'h3F8CCCCD},
    {3'd1, 32'h40400000, 32'h3F800000, 32'h40000000},
    {3'd0, 32'h3F800000, 32'hBF800000, 32'h00000000},
    {3'd2, 32'h40000000, 32'h40400000, 32'h40C00000},
    {3'd2, 32'h7F000000, 32'h40000000, 32'h7F800000},
    {3'd0, 32'h7F800000, 32'hFF800000, 32'h7FC00000},
    {3'd4, 32'h3F800000, 32'h00000000, 32'hBF800000},
    {3'd7, 32'hBF800000, 32'h3F800000, 32'h00000001},
    {3'd6, 32'h00000000, 32'h80000000, 32'h00000001},
    {3'd6, 32'h7FC00000, 32'h7FC00000, 32'h00000000},
    {3'd2, 32'h00000000, 32'h7F800000, 32'h7FC00000},
    {3'd0, 32'h7F800000, 32'h3F800000, 32'h7F800000},
    {3'd3, 32'hC0490FDB, 32'h00000000, 32'h40490FDB},
    {3'd5, 32'h12345678, 32'h00000000, 32'h12345678},
    {3'd2, 32'h00400000, 32'h40000000, 32'h00000000},
    {3'd2, 32'h80400000, 32'h40000000, 32'h80000000},
    {3'd2, 32'h1F800000, 32'h1F800000, 32'h00000000},
    {3'd0, 32'h3F800000, 32'h33800000, 32'h3F800000},
    {3'd0, 32'h3F800001, 32'h33800000, 32'h3F800002},
    {3'd1, 32'h3F800000, 32'h3F7FFFFF, 32'h33800000},
    {3'd7, 32'h80000000, 32'h00000000, 32'h00000000},
    {3'd7, 32'hFF800000, 32'hC0000000, 32'h00000001}
  };

  initial begin : stimulus
    bit [98:0] row;
    bit [31:0] a;
    bit [31:0] b;
    bit [2:0]  o;
    int        base;

    rst_n = 1'b0;
    op    = 3'd0;
    data1 = 32'h0;
    data2 = 32'h0;
    repeat (2) @(negedge clk);
    check("reset_value", floatRes, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      row = directed[i];
      issue(row[98:96], row[95:64], row[63:32], row[31:0]);
    end

    // Asynchronous reset between edges, then a normal op after release.
    issue(3'd2, 32'h40000000, 32'h40400000, 32'h40C00000);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", floatRes, 32'h0);
    @(negedge clk);
    op    = 3'd0;
    data1 = 32'h3F800000;
    data2 = 32'h3F800000;
    @(posedge clk);
    #2;
    check("reset_hold", floatRes, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(3'd1, 32'h40400000, 32'h3F800000, 32'h40000000);

    for (int i = 0; i < 3000; i++) begin
      o    = 3'($urandom_range(0, 7));
      base = int'($urandom_range(1, 254));
      a    = rnd_operand(base);
      case ($urandom_range(0, 7))
        0:       b = a;
        1:       b = {~a[31], a[30:0] + 31'($urandom_range(0, 3))};
        default: b = rnd_operand(base);
      endcase
      issue(o, a, b, model(o, a, b));
    end

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d results pending, want 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
